// File: rtl/knap_pkg.sv
// Shared constants and state encoding for the exhaustive knapsack search.
// Optional KNAP_COUNT_EN build adds a feasible-subset counter output.
package knap_pkg;
    localparam int N_ITEMS = 5;
    localparam int VW      = 7;
    localparam int SUM_W   = VW + 3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;
endpackage

// File: rtl/knap_eval.sv
// Combinational subset evaluator: masked sums of value, weight and volume
// against the latched limits.
module knap_eval #(
    parameter int N_ITEMS = knap_pkg::N_ITEMS,
    parameter int VW      = knap_pkg::VW
) (
    input  logic [N_ITEMS-1:0][VW-1:0] value,
    input  logic [N_ITEMS-1:0][VW-1:0] weight,
    input  logic [N_ITEMS-1:0][VW-1:0] volume,
    input  logic [N_ITEMS-1:0]         mask,
    input  logic [VW-1:0]              min_value,
    input  logic [VW-1:0]              max_weight,
    input  logic [VW-1:0]              max_volume,
    output logic [VW+2:0]              tot_value,
    output logic                       feasible
);
    localparam int SW = VW + 3;

    logic [SW-1:0] tot_weight;
    logic [SW-1:0] tot_volume;

    // Three extra bits hold the sum of up to eight full-scale items exactly.
    always_comb begin
        tot_value  = '0;
        tot_weight = '0;
        tot_volume = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (mask[i]) begin
                tot_value  = tot_value + SW'(value[i]);
                tot_weight = tot_weight + SW'(weight[i]);
                tot_volume = tot_volume + SW'(volume[i]);
            end
        end
        feasible = (tot_value >= SW'(min_value)) &&
                   (tot_weight <= SW'(max_weight)) &&
                   (tot_volume <= SW'(max_volume));
    end
endmodule

// File: rtl/knap_search.sv
// Exhaustive knapsack search: one subset per cycle, keeps the best value.
// Define KNAP_COUNT_EN to add the feas_count output.
module knap_search #(
    parameter int N_ITEMS = knap_pkg::N_ITEMS,
    parameter int VW      = knap_pkg::VW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(N_ITEMS)-1:0] cfg_idx,
    input  logic [VW-1:0]              cfg_value,
    input  logic [VW-1:0]              cfg_weight,
    input  logic [VW-1:0]              cfg_volume,
    input  logic [VW-1:0]              min_value,
    input  logic [VW-1:0]              max_weight,
    input  logic [VW-1:0]              max_volume,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [N_ITEMS-1:0]         best_mask,
    output logic [VW+2:0]              best_value
`ifdef KNAP_COUNT_EN
    ,
    output logic [N_ITEMS:0]           feas_count
`endif
);
    import knap_pkg::*;

    localparam int SW = VW + 3;

    state_t                    state;
    logic [N_ITEMS:0]          mask;
    logic [N_ITEMS-1:0][VW-1:0] tbl_value;
    logic [N_ITEMS-1:0][VW-1:0] tbl_weight;
    logic [N_ITEMS-1:0][VW-1:0] tbl_volume;
    logic [VW-1:0]             lim_value;
    logic [VW-1:0]             lim_weight;
    logic [VW-1:0]             lim_volume;
    logic [SW-1:0]             tot_value;
    logic                      feasible;

    knap_eval #(
        .N_ITEMS (N_ITEMS),
        .VW      (VW)
    ) u_eval (
        .value      (tbl_value),
        .weight     (tbl_weight),
        .volume     (tbl_volume),
        .mask       (mask[N_ITEMS-1:0]),
        .min_value  (lim_value),
        .max_weight (lim_weight),
        .max_volume (lim_volume),
        .tot_value  (tot_value),
        .feasible   (feasible)
    );

    // mask's top bit marks the scan as exhausted, giving one settle cycle before DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask       <= '0;
            tbl_value  <= '0;
            tbl_weight <= '0;
            tbl_volume <= '0;
            lim_value  <= '0;
            lim_weight <= '0;
            lim_volume <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            best_mask  <= '0;
            best_value <= '0;
`ifdef KNAP_COUNT_EN
            feas_count <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cfg_we && (int'(cfg_idx) < N_ITEMS)) begin
                        tbl_value[cfg_idx]  <= cfg_value;
                        tbl_weight[cfg_idx] <= cfg_weight;
                        tbl_volume[cfg_idx] <= cfg_volume;
                    end
                    if (start) begin
                        lim_value  <= min_value;
                        lim_weight <= max_weight;
                        lim_volume <= max_volume;
                        found      <= 1'b0;
                        best_mask  <= '0;
                        best_value <= '0;
                        mask       <= '0;
                        busy       <= 1'b1;
                        state      <= SCAN;
`ifdef KNAP_COUNT_EN
                        feas_count <= '0;
`endif
                    end
                end
                SCAN: begin
                    if (mask[N_ITEMS]) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        if (feasible && (!found || tot_value > best_value)) begin
                            found      <= 1'b1;
                            best_mask  <= mask[N_ITEMS-1:0];
                            best_value <= tot_value;
                        end
`ifdef KNAP_COUNT_EN
                        if (feasible) feas_count <= feas_count + 1'b1;
`endif
                        mask <= mask + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_knap_search.sv
// Bench for knap_search: vector table plus reset and mid-scan sequences.
// Expected results are hand-derived and queued when each search starts.
module tb_knap_search;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [2:0]        cfg_idx;
    logic [6:0]        cfg_value, cfg_weight, cfg_volume;
    logic [6:0]        min_value, max_weight, max_volume;
    logic              start;
    logic              busy, done, found;
    logic [4:0]        best_mask;
    logic [9:0]        best_value;
`ifdef KNAP_COUNT_EN
    logic [5:0]        feas_count;
`endif

    always #5 clk = ~clk;

    knap_search dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_value  (cfg_value),
        .cfg_weight (cfg_weight),
        .cfg_volume (cfg_volume),
        .min_value  (min_value),
        .max_weight (max_weight),
        .max_volume (max_volume),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .best_mask  (best_mask),
        .best_value (best_value)
`ifdef KNAP_COUNT_EN
        ,
        .feas_count (feas_count)
`endif
    );

    typedef logic [4:0][6:0] tbl_t;

    typedef struct {
        string      name;
        logic       found;
        logic [4:0] mask;
        logic [9:0] value;
        int         count;
    } exp_t;

    typedef struct {
        tbl_t       v, w, vol;
        logic [6:0] minv, maxw, maxvol;
        exp_t       e;
    } vec_t;

    exp_t  sb[$];
    vec_t  vt[11];
    int    checks = 0;
    int    errors = 0;
    time   t0;

    tbl_t  t_v   = {7'd10, 7'd20, 7'd1, 7'd8, 7'd4};
    tbl_t  t_w   = {7'd27, 7'd18, 7'd27, 7'd8, 7'd28};
    tbl_t  t_vol = {7'd1, 7'd4, 7'd4, 7'd27, 7'd27};
    tbl_t  t_0   = '0;
    tbl_t  t_127 = {5{7'd127}};

    function automatic exp_t mke(string n, logic f, logic [4:0] m, logic [9:0] val, int c);
        exp_t e;
        e.name = n; e.found = f; e.mask = m; e.value = val; e.count = c;
        return e;
    endfunction

    function automatic vec_t mkv(tbl_t v, tbl_t w, tbl_t vol,
                                 logic [6:0] mn, logic [6:0] mw, logic [6:0] mv, exp_t e);
        vec_t r;
        r.v = v; r.w = w; r.vol = vol;
        r.minv = mn; r.maxw = mw; r.maxvol = mv; r.e = e;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(tbl_t v, tbl_t w, tbl_t vol);
        for (int i = 0; i < 5; i++) begin
            cfg_we = 1'b1; cfg_idx = 3'(i);
            cfg_value = v[i]; cfg_weight = w[i]; cfg_volume = vol[i];
            @(posedge clk); #1;
        end
        cfg_we = 1'b0;
    endtask

    task automatic start_search(logic [6:0] mn, logic [6:0] mw, logic [6:0] mv, exp_t e);
        min_value = mn; max_weight = mw; max_volume = mv;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        t0 = $time;
        #1;
        start = 1'b0;
        min_value  = 7'($urandom);
        max_weight = 7'($urandom);
        max_volume = 7'($urandom);
    endtask

    task automatic check_results(exp_t e, string tag);
        chk({e.name, tag, ".found"}, 32'(found), 32'(e.found));
        chk({e.name, tag, ".mask"}, 32'(best_mask), 32'(e.mask));
        chk({e.name, tag, ".value"}, 32'(best_value), 32'(e.value));
`ifdef KNAP_COUNT_EN
        chk({e.name, tag, ".count"}, 32'(feas_count), 32'(e.count));
`endif
    endtask

    task automatic wait_done(int budget);
        bit   seen = 0;
        time  tedge;
        int   lat = 0;
        exp_t e;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk);
            tedge = $time;
            #1;
            if (done) begin
                seen = 1;
                lat  = int'((tedge - t0) / 10);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got done expected no pending search");
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".latency"}, 32'(lat), 32'd33);
        check_results(e, "");
        @(posedge clk); #1;
        chk({e.name, ".done_pulse"}, 32'(done), 32'd0);
        chk({e.name, ".busy_after"}, 32'(busy), 32'd0);
    endtask

    exp_t e034, e_cleared;

    initial begin
        bit saw;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_value = '0; cfg_weight = '0; cfg_volume = '0;
        min_value = '0; max_weight = '0; max_volume = '0; start = 1'b0;

        e034      = mke("basic", 1'b1, 5'b11000, 10'd30, 1);
        e_cleared = mke("cleared_tbl", 1'b0, 5'b0, 10'd0, 0);
        vt[0]  = mkv(t_v, t_w, t_vol, 7'd30, 7'd50, 7'd50, e034);
        vt[1]  = mkv(t_v, t_w, t_vol, 7'd31, 7'd50, 7'd50, mke("min31", 1'b0, 5'b0, 10'd0, 0));
        vt[2]  = mkv(t_0, t_0, t_0, 7'd0, 7'd0, 7'd0, mke("all_zero", 1'b1, 5'b0, 10'd0, 32));
        vt[3]  = mkv(t_v, t_w, t_vol, 7'd0, 7'd127, 7'd127, mke("all_fit", 1'b1, 5'b11111, 10'd43, 32));
        vt[4]  = mkv(t_v, t_w, t_vol, 7'd0, 7'd0, 7'd127, mke("empty_only", 1'b1, 5'b0, 10'd0, 1));
        vt[5]  = mkv(t_v, t_w, t_vol, 7'd28, 7'd26, 7'd31, mke("exact_lim", 1'b1, 5'b01010, 10'd28, 1));
        vt[6]  = mkv(t_v, t_w, t_vol, 7'd21, 7'd25, 7'd31, mke("wt_over", 1'b0, 5'b0, 10'd0, 0));
        vt[7]  = mkv(t_v, t_w, t_vol, 7'd21, 7'd26, 7'd30, mke("vol_over", 1'b0, 5'b0, 10'd0, 0));
        vt[8]  = mkv({7'd0, 7'd0, 7'd0, 7'd5, 7'd5}, {7'd10, 7'd10, 7'd10, 7'd1, 7'd1}, t_0,
                     7'd0, 7'd1, 7'd0, mke("tie", 1'b1, 5'b00001, 10'd5, 3));
        vt[9]  = mkv(t_127, t_0, t_0, 7'd127, 7'd0, 7'd0, mke("big_value", 1'b1, 5'b11111, 10'd635, 31));
        vt[10] = mkv(t_127, t_127, t_0, 7'd0, 7'd127, 7'd0, mke("big_weight", 1'b1, 5'b00001, 10'd127, 6));

        #1;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        check_results(mke("reset", 1'b0, 5'b0, 10'd0, 0), "");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            load(vt[i].v, vt[i].w, vt[i].vol);
            start_search(vt[i].minv, vt[i].maxw, vt[i].maxvol, vt[i].e);
            chk({vt[i].e.name, ".busy"}, 32'(busy), 32'd1);
            wait_done(60);
        end

        // Results must hold across idle cycles.
        repeat (5) @(posedge clk);
        #1 check_results(vt[10].e, ".hold");

        // Start and table write mid-scan must both be ignored.
        load(t_v, t_w, t_vol);
        start_search(7'd30, 7'd50, 7'd50, mke("midscan", 1'b1, 5'b11000, 10'd30, 1));
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd3;
        cfg_value = 7'd60; cfg_weight = 7'd0; cfg_volume = 7'd0;
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0;
        chk("midscan.busy", 32'(busy), 32'd1);
        wait_done(60);

        // Asynchronous reset mid-scan.
        start_search(7'd0, 7'd127, 7'd127, mke("aborted", 1'b1, 5'b11111, 10'd43, 32));
        repeat (14) @(posedge clk);
        #1;
        chk("abort.busy_before", 32'(busy), 32'd1);
        chk("abort.found_before", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        check_results(mke("abort", 1'b0, 5'b0, 10'd0, 0), "");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        saw = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) saw = 1;
        end
        chk("abort.no_done", 32'(saw), 32'd0);

        start_search(7'd30, 7'd50, 7'd50, e_cleared);
        wait_done(60);
        load(t_v, t_w, t_vol);
        start_search(7'd30, 7'd50, 7'd50, mke("after_reset", 1'b1, 5'b11000, 10'd30, 1));
        wait_done(60);

        chk("scoreboard.empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/knap_search.md
KNAP_SEARCH -- requirements
Module: knap_search

Interface
REQ-001 SHALL have parameter N_ITEMS, default 5, meaning number of items and subset-mask width.
REQ-002 SHALL have parameter VW, default 7, meaning width of each per-item value, weight and volume, and of each limit.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port cfg_we, input, 1, meaning write item table entry cfg_idx.
REQ-006 SHALL have port cfg_idx, input, $clog2(N_ITEMS), meaning item index; writes with idx >= N_ITEMS are dropped.
REQ-007 SHALL have ports cfg_value, cfg_weight and cfg_volume, each input, VW, meaning item attributes to write.
REQ-008 SHALL have ports min_value, max_weight and max_volume, each input, VW, meaning limits, sampled only on an accepted start.
REQ-009 SHALL have port start, input, 1, meaning request an exhaustive search.
REQ-010 SHALL have port busy, output, 1, meaning search in progress.
REQ-011 SHALL have port done, output, 1, meaning one-cycle pulse when results are final.
REQ-012 SHALL have port found, output, 1, meaning at least one feasible subset exists.
REQ-013 SHALL have ports best_mask, output, N_ITEMS, and best_value, output, VW+3, meaning the winning subset (bit i = item i) and its total value.

Function
REQ-014 SHALL implement states IDLE, SCAN and DONE.
REQ-015 IDLE SHALL, on start=1, latch the limits, clear found, best_mask, best_value and mask counter, and go to SCAN.
REQ-016 SCAN SHALL evaluate one subset per cycle, with masks 0 through 2^N_ITEMS-1 in ascending order, then go to DONE after the last mask.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 Latency SHALL be 2^N_ITEMS+1 cycles from the start-sampling edge to done high (33 cycles for N_ITEMS=5).
REQ-019 A subset SHALL be feasible iff sum(value) >= min_value, sum(weight) <= max_weight and sum(volume) <= max_volume.
REQ-020 Sums SHALL be computed at VW+3 bits and SHALL neither wrap nor saturate; limits are zero-extended before comparison.
REQ-021 The best result SHALL be replaced only by a feasible subset with strictly greater value; on ties the earliest (lowest) mask is kept.
REQ-022 The first feasible subset SHALL always be taken and SHALL set found=1.
REQ-023 The empty subset (mask 0) SHALL be feasible iff min_value=0.
REQ-024 busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 cfg_we SHALL be ignored while busy=1; the item table is stable during a scan.
REQ-027 found, best_mask and best_value SHALL hold from done until the next accepted start.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and busy=0, done=0, found=0, best_mask=0, best_value=0, and clear the item table.
REQ-029 Reset mid-scan SHALL abort the scan with no done pulse.

Configuration
REQ-030 With KNAP_COUNT_EN defined, the block SHALL add output feas_count, N_ITEMS+1 bits, cleared on start and reset, incremented once per feasible subset, and held with the other results.
REQ-031 With KNAP_COUNT_EN undefined, the port and its counter SHALL be absent.

Structure
REQ-032 Package knap_pkg SHALL hold the state enum, N_ITEMS, VW and the sum-width constant.
REQ-033 Sub-module knap_eval (combinational: item table, mask and limits to totals and feasible) SHALL compute the sums and feasibility.

Verification
REQ-034 Load items (v,w,vol) = A(4,28,27), B(8,8,27), C(1,27,4), D(20,18,4), E(10,27,1) at idx 0..4, limits 30/50/50, start -> done after 33 cycles, found=1, best_mask=5'b11000, best_value=30, feas_count=1.
REQ-035 Same table with min_value=31 -> found=0, best_mask=0, best_value=0, feas_count=0.
REQ-036 All items (0,0,0), limits 0/0/0 -> best_mask=0 (tie rule), best_value=0, feas_count=32.
REQ-037 start pulsed, and cfg_we of idx 3 to (60,0,0), at cycle 10 of a scan -> both ignored; results match REQ-034.
REQ-038 rst_n low at cycle 15 of a scan -> busy=0 and all outputs 0 immediately; no done pulse; a new start after re-load gives the REQ-034 results.
